// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for IF / MEM / LDR with fetch anti-starvation and a loader lock.
// Optional ACCESS_CNT_EN adds saturating per-requester access counters.
module mem_port_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_lock,
  output logic          lock_ack,
  output logic          if_gnt,
  output logic          mem_gnt,
  output logic          ldr_gnt,
  output logic          if_rvalid,
  output logic          mem_rvalid,
  output logic          ldr_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          cnt_clr,
  output logic [31:0]   cnt_if_rd,
  output logic [31:0]   cnt_mem_rd,
  output logic [31:0]   cnt_mem_wr,
  output logic [31:0]   cnt_ldr
);

  typedef enum logic {S_ARB, S_LOCK} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       if_e, mem_e, ldr_e;
  logic       win_if, win_mem, win_ldr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_ARB;
    else        state_q <= state_d;
  end

  // ldr_lock blocks IF/MEM at the entry edge and every edge while held,
  // so arbitration keys off the input rather than the registered state.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      S_ARB:   if (ldr_lock)  state_d = S_LOCK;
      S_LOCK:  if (!ldr_lock) state_d = S_ARB;
      default: state_d = S_ARB;
    endcase

    if_e  = if_req  & ~if_gnt  & ~ldr_lock;
    mem_e = mem_req & ~mem_gnt & ~ldr_lock;
    ldr_e = ldr_req & ~ldr_gnt;

    win_ldr = ldr_e;
    win_if  = ~ldr_e & if_e & ((starve_q == LIM) | ~mem_e);
    win_mem = ~ldr_e & mem_e & ~win_if;

    if (!if_req || win_if)                 starve_d = '0;
    else if (!if_gnt && starve_q != LIM)   starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      if_gnt     <= 1'b0;
      mem_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_rvalid  <= 1'b0;
      mem_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
    end else begin
      starve_q <= starve_d;
      if_gnt   <= win_if;
      mem_gnt  <= win_mem;
      ldr_gnt  <= win_ldr;
      ram_en   <= win_if | win_mem | win_ldr;
      ram_we   <= 1'b0;
      if (win_ldr) begin
        ram_we    <= ldr_we;
        ram_addr  <= ldr_addr;
        ram_wdata <= ldr_wdata;
      end else if (win_mem) begin
        ram_we    <= mem_we;
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
      end else if (win_if) begin
        ram_addr  <= if_addr;
      end
      // The gnt flags act as the in-flight read tag for the next cycle.
      if_rvalid  <= if_gnt  & ~ram_we;
      mem_rvalid <= mem_gnt & ~ram_we;
      ldr_rvalid <= ldr_gnt & ~ram_we;
    end
  end

  assign lock_ack = (state_q == S_LOCK);
  assign rdata    = ram_rdata;

`ifdef ACCESS_CNT_EN
  logic [31:0] c_if_rd, c_mem_rd, c_mem_wr, c_ldr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_if_rd  <= '0;
      c_mem_rd <= '0;
      c_mem_wr <= '0;
      c_ldr    <= '0;
    end else if (cnt_clr) begin
      c_if_rd  <= '0;
      c_mem_rd <= '0;
      c_mem_wr <= '0;
      c_ldr    <= '0;
    end else begin
      if (win_if && c_if_rd != '1)              c_if_rd  <= c_if_rd + 32'd1;
      if (win_mem && !mem_we && c_mem_rd != '1) c_mem_rd <= c_mem_rd + 32'd1;
      if (win_mem && mem_we && c_mem_wr != '1)  c_mem_wr <= c_mem_wr + 32'd1;
      if (win_ldr && c_ldr != '1)               c_ldr    <= c_ldr + 32'd1;
    end
  end

  assign cnt_if_rd  = c_if_rd;
  assign cnt_mem_rd = c_mem_rd;
  assign cnt_mem_wr = c_mem_wr;
  assign cnt_ldr    = c_ldr;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_if_rd  = '0;
  assign cnt_mem_rd = '0;
  assign cnt_mem_wr = '0;
  assign cnt_ldr    = '0;
`endif

endmodule
